spi_arbiter: RTL

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/spi_arbiter.sv
// spi_arbiter: two-requester round-robin arbiter in front of a single SPI engine.
// A granted requester's length/opcode are latched and handed to the engine with a
// one-cycle work pulse; the transaction ends when the engine drops busy, when busy
// never rises within TIMEOUT cycles (err), or at once for a zero-length request.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   req0/1            level requests
//   len0/1, op0/1     requested transfer length and opcode (0 write, 1 read)
//   grant0/1          ownership of the engine (one-hot or zero)
//   done0/1           one-cycle completion pulse to the owner
//   sel               FIFO-path steering, held from grant until the next grant
//   work              one-cycle start pulse to the engine
//   len, op           latched transfer length / opcode to the engine
//   busy              engine transfer in progress
//   err               one-cycle timeout flag, coincident with done
module spi_arbiter #(
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic             op0,
  input  logic             op1,
  output logic             grant0,
  output logic             grant1,
  output logic             done0,
  output logic             done1,
  output logic             sel,
  output logic             work,
  output logic [LEN_W-1:0] len,
  output logic             op,
  input  logic             busy,
  output logic             err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    WAIT_BSY = 3'd2,
    RUN      = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;     // requester served last
  logic [1:0]         grant_q, grant_d;
  logic [1:0]         done_q, done_d;
  logic               sel_q, sel_d;
  logic               work_q, work_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               op_q, op_d;
  logic               err_q, err_d;
  logic               pick;
  logic [LEN_W-1:0]   pick_len;

  // State and output registers; reset leaves the pointer favouring requester 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      grant_q <= '0;
      done_q  <= '0;
      sel_q   <= 1'b0;
      work_q  <= 1'b0;
      len_q   <= '0;
      op_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      sel_q   <= sel_d;
      work_q  <= work_d;
      len_q   <= len_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    grant_d  = grant_q;
    sel_d    = sel_q;
    len_d    = len_q;
    op_d     = op_q;
    work_d   = 1'b0;
    done_d   = '0;
    err_d    = 1'b0;
    pick     = 1'b0;
    pick_len = len0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie, serve the requester that was not served last.
          pick     = (req0 && req1) ? ~last_q : req1;
          pick_len = pick ? len1 : len0;
          grant_d  = pick ? 2'b10 : 2'b01;
          sel_d    = pick;
          len_d    = pick_len;
          op_d     = pick ? op1 : op0;
          if (pick_len == '0) begin
            // Nothing to transfer: complete without starting the engine.
            state_d = DONE;
            done_d  = pick ? 2'b10 : 2'b01;
          end else begin
            state_d = START;
            work_d  = 1'b1;
          end
        end
      end

      START: begin
        state_d = WAIT_BSY;
        cnt_d   = '0;
      end

      WAIT_BSY: begin
        if (busy) begin
          state_d = RUN;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = DONE;
          done_d  = grant_q;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RUN: begin
        if (!busy) begin
          state_d = DONE;
          done_d  = grant_q;
        end
      end

      DONE: begin
        grant_d = '0;
        last_d  = sel_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign grant0 = grant_q[0];
  assign grant1 = grant_q[1];
  assign done0  = done_q[0];
  assign done1  = done_q[1];
  assign sel    = sel_q;
  assign work   = work_q;
  assign len    = len_q;
  assign op     = op_q;
  assign err    = err_q;

endmodule
